// File: rtl/translated_addressing_pkg.sv
// Shared address-translation helpers and parameter sanity checks for the
// translated register bank (write decode and optional read decode).
package translated_addressing_pkg;

  localparam int unsigned MAX_ADDR_WIDTH = 32;
  localparam int unsigned MAX_ENTRY_ADDR_WIDTH = 32;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned base,
                                         input int unsigned count);
    // Subtract only after the lower bound holds, so the top of the space cannot wrap
    return (addr >= base) && ((addr - base) < count);
  endfunction

  function automatic int unsigned addr_offset(input int unsigned addr, input int unsigned base);
    return addr - base;
  endfunction

  function automatic bit params_ok(input int unsigned addr_width,
                                   input int unsigned entry_addr_width,
                                   input int unsigned base, input int unsigned count);
    longint unsigned addr_span;
    longint unsigned entry_span;
    if (addr_width == 0 || addr_width > MAX_ADDR_WIDTH) return 1'b0;
    if (entry_addr_width == 0 || entry_addr_width > MAX_ENTRY_ADDR_WIDTH) return 1'b0;
    if (count == 0) return 1'b0;
    addr_span = longint'(1) << addr_width;
    entry_span = longint'(1) << entry_addr_width;
    if (longint'(base) + longint'(count) > addr_span) return 1'b0;
    if (longint'(count) > entry_span) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/translated_address_decoder.sv
// Combinational global-address to entry-index translation: hit when the address
// falls inside the bank window, index is the offset from the window base.
module translated_address_decoder
  import translated_addressing_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 11,
  parameter int unsigned ENTRY_ADDR_WIDTH = 3,
  parameter int unsigned ENTRY_BASE_ADDR  = 123,
  parameter int unsigned ENTRY_COUNT      = 8
) (
  input  logic [ADDR_WIDTH-1:0]       addr,
  output logic                        hit,
  output logic [ENTRY_ADDR_WIDTH-1:0] index
);

  int unsigned addr_u;

  assign addr_u = 32'(addr);
  assign hit    = addr_in_range(addr_u, ENTRY_BASE_ADDR, ENTRY_COUNT);
  assign index  = ENTRY_ADDR_WIDTH'(addr_offset(addr_u, ENTRY_BASE_ADDR));

endmodule

// File: rtl/translated_addressed_register_bank.sv
// Register bank mapped into a global address window, with a two-stage write
// pipeline and sticky written flags. TRANSLATED_BANK_READBACK_EN adds a read port.
module translated_addressed_register_bank
  import translated_addressing_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH       = 36,
  parameter int unsigned           ADDR_WIDTH       = 11,
  parameter int unsigned           ENTRY_COUNT      = 8,
  parameter int unsigned           ENTRY_BASE_ADDR  = 123,
  parameter int unsigned           ENTRY_ADDR_WIDTH = 3,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE      = '0,
  parameter int unsigned           TOTAL_WIDTH      = ENTRY_COUNT * WORD_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [WORD_WIDTH-1:0]  wr_data,
  output logic                   wr_hit,
  output logic [TOTAL_WIDTH-1:0] bank,
  output logic [ENTRY_COUNT-1:0] written,
  input  logic                   written_clear
`ifdef TRANSLATED_BANK_READBACK_EN
  ,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [WORD_WIDTH-1:0]  rd_data
`endif
);

  if (!params_ok(ADDR_WIDTH, ENTRY_ADDR_WIDTH, ENTRY_BASE_ADDR, ENTRY_COUNT)) begin : gen_bad_params
    $error("translated_addressed_register_bank: address window or entry index width invalid");
  end

  logic                        wr_dec_hit;
  logic [ENTRY_ADDR_WIDTH-1:0] wr_dec_index;

  logic                        s1_valid_q;
  logic [ENTRY_ADDR_WIDTH-1:0] s1_index_q;
  logic [WORD_WIDTH-1:0]       s1_data_q;

  logic [WORD_WIDTH-1:0]       entry_q [ENTRY_COUNT];
  logic [ENTRY_COUNT-1:0]      written_q;
  logic [ENTRY_COUNT-1:0]      written_d;
  logic [ENTRY_COUNT-1:0]      upd_onehot;
  logic                        wr_hit_q;

  translated_address_decoder #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .ENTRY_ADDR_WIDTH(ENTRY_ADDR_WIDTH),
    .ENTRY_BASE_ADDR (ENTRY_BASE_ADDR),
    .ENTRY_COUNT     (ENTRY_COUNT)
  ) u_wr_dec (
    .addr (wr_addr),
    .hit  (wr_dec_hit),
    .index(wr_dec_index)
  );

  // Stage 1: capture the translated request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_index_q <= '0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= wr_en & wr_dec_hit;
      s1_index_q <= wr_dec_index;
      s1_data_q  <= wr_data;
    end
  end

  always_comb begin
    upd_onehot = '0;
    if (s1_valid_q) upd_onehot[s1_index_q] = 1'b1;
  end

  // A clear on the update edge must not hide that entry's fresh write
  always_comb begin
    written_d = written_clear ? '0 : written_q;
    written_d = written_d | upd_onehot;
  end

  // Stage 2: commit to the entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRY_COUNT); i++) entry_q[i] <= RESET_VALUE;
      written_q <= '0;
      wr_hit_q  <= 1'b0;
    end else begin
      if (s1_valid_q) entry_q[s1_index_q] <= s1_data_q;
      written_q <= written_d;
      wr_hit_q  <= s1_valid_q;
    end
  end

  always_comb begin
    bank = '0;
    for (int i = 0; i < int'(ENTRY_COUNT); i++) bank[i*WORD_WIDTH +: WORD_WIDTH] = entry_q[i];
  end

  assign written = written_q;
  assign wr_hit  = wr_hit_q;

`ifdef TRANSLATED_BANK_READBACK_EN
  logic                        rd_dec_hit;
  logic [ENTRY_ADDR_WIDTH-1:0] rd_dec_index;
  logic [WORD_WIDTH-1:0]       rd_data_q;

  translated_address_decoder #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .ENTRY_ADDR_WIDTH(ENTRY_ADDR_WIDTH),
    .ENTRY_BASE_ADDR (ENTRY_BASE_ADDR),
    .ENTRY_COUNT     (ENTRY_COUNT)
  ) u_rd_dec (
    .addr (rd_addr),
    .hit  (rd_dec_hit),
    .index(rd_dec_index)
  );

  // Samples the pre-update entry, giving read-before-write on a same-edge update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_dec_hit ? entry_q[rd_dec_index] : '0;
  end

  assign rd_data = rd_data_q;
`else
  // Write-only bank: no read decode or read data register
`endif

endmodule

// File: tb/tb_translated_addressed_register_bank.sv
// Self-checking bench: directed vector table, hand sequences for reset/readback,
// and randomized traffic against a queue-based behavioural model.
module tb_translated_addressed_register_bank;

  localparam int WW = 36;
  localparam int AW = 11;
  localparam int EC = 8;
  localparam int BASE = 123;

  logic             clock = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WW-1:0]    wr_data;
  logic             wr_hit;
  logic [EC*WW-1:0] bank;
  logic [EC-1:0]    written;
  logic             written_clear;
`ifdef TRANSLATED_BANK_READBACK_EN
  logic [AW-1:0]    rd_addr;
  logic [WW-1:0]    rd_data;
`endif

  translated_addressed_register_bank dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_hit       (wr_hit),
    .bank         (bank),
    .written      (written),
    .written_clear(written_clear)
`ifdef TRANSLATED_BANK_READBACK_EN
    ,
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural model: entry array, flag word, and a queue of requests awaiting commit
  typedef struct {
    bit          valid;
    int          idx;
    logic [WW-1:0] data;
  } req_t;

  logic [WW-1:0] m_mem [EC];
  logic [EC-1:0] m_written;
  logic          m_hit;
  logic [WW-1:0] m_rd;
  req_t          m_pend[$];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_window(input int a);
    return a >= BASE && a < BASE + EC;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < EC; i++) m_mem[i] = '0;
    m_written = '0;
    m_hit = 1'b0;
    m_rd = '0;
    m_pend.delete();
  endtask

  task automatic compare_model(input string tag);
    for (int i = 0; i < EC; i++)
      chk($sformatf("%s entry%0d", tag, i), 64'(bank[i*WW +: WW]), 64'(m_mem[i]));
    chk({tag, " wr_hit"}, 64'(wr_hit), 64'(m_hit));
    chk({tag, " written"}, 64'(written), 64'(m_written));
`ifdef TRANSLATED_BANK_READBACK_EN
    chk({tag, " rd_data"}, 64'(rd_data), 64'(m_rd));
`endif
  endtask

  // One clock: drive inputs, advance the model across the edge, compare after it
  task automatic step(input logic we, input logic [AW-1:0] a, input logic [WW-1:0] d,
                      input logic clr, input string tag);
    req_t p;
    req_t n;
    wr_en = we;
    wr_addr = a;
    wr_data = d;
    written_clear = clr;
`ifdef TRANSLATED_BANK_READBACK_EN
    m_rd = in_window(int'(rd_addr)) ? m_mem[int'(rd_addr) - BASE] : '0;
`endif
    m_hit = 1'b0;
    if (clr) m_written = '0;
    if (m_pend.size() != 0) begin
      p = m_pend.pop_front();
      if (p.valid) begin
        m_mem[p.idx] = p.data;
        m_written[p.idx] = 1'b1;
        m_hit = 1'b1;
      end
    end
    n.valid = we && in_window(int'(a));
    n.idx = int'(a) - BASE;
    n.data = d;
    m_pend.push_back(n);
    @(posedge clock);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset(input string tag);
    wr_en = 1'b0;
    written_clear = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    compare_model({tag, " in-reset"});
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic          clr;
    logic          exp_hit;
    logic [EC-1:0] exp_written;
    int            chk_idx;
    logic [WW-1:0] exp_entry;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [63:0] r;
    logic [AW-1:0] ra;

    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    written_clear = 1'b0;
`ifdef TRANSLATED_BANK_READBACK_EN
    rd_addr = '0;
`endif
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare_model("reset");
    reset = 1'b0;

    // Expected values are the state just after the edge that samples each row
    vecs.push_back('{1'b1, 11'd125, 36'hABC, 1'b0, 1'b0, 8'h00, 2, 36'h0});
    vecs.push_back('{1'b0, 11'd0,   36'h0,   1'b0, 1'b1, 8'h04, 2, 36'hABC});
    vecs.push_back('{1'b0, 11'd0,   36'h0,   1'b0, 1'b0, 8'h04, 2, 36'hABC});
    vecs.push_back('{1'b1, 11'd122, 36'h111, 1'b0, 1'b0, 8'h04, 2, 36'hABC});
    vecs.push_back('{1'b1, 11'd131, 36'h222, 1'b0, 1'b0, 8'h04, 2, 36'hABC});
    vecs.push_back('{1'b0, 11'd0,   36'h0,   1'b0, 1'b0, 8'h04, 7, 36'h0});
    vecs.push_back('{1'b1, 11'd130, 36'h1,   1'b0, 1'b0, 8'h04, 7, 36'h0});
    vecs.push_back('{1'b1, 11'd130, 36'h2,   1'b0, 1'b1, 8'h84, 7, 36'h1});
    vecs.push_back('{1'b1, 11'd130, 36'h3,   1'b0, 1'b1, 8'h84, 7, 36'h2});
    vecs.push_back('{1'b0, 11'd0,   36'h0,   1'b0, 1'b1, 8'h84, 7, 36'h3});
    vecs.push_back('{1'b0, 11'd0,   36'h0,   1'b0, 1'b0, 8'h84, 7, 36'h3});
    vecs.push_back('{1'b1, 11'd123, 36'h55,  1'b0, 1'b0, 8'h84, 0, 36'h0});
    vecs.push_back('{1'b0, 11'd0,   36'h0,   1'b1, 1'b1, 8'h01, 0, 36'h55});
    vecs.push_back('{1'b1, 11'd124, 36'h9,   1'b1, 1'b0, 8'h00, 1, 36'h0});
    vecs.push_back('{1'b0, 11'd0,   36'h0,   1'b0, 1'b1, 8'h02, 1, 36'h9});

    for (int v = 0; v < vecs.size(); v++) begin
      step(vecs[v].we, vecs[v].addr, vecs[v].data, vecs[v].clr, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d tbl wr_hit", v), 64'(wr_hit), 64'(vecs[v].exp_hit));
      chk($sformatf("vec%0d tbl written", v), 64'(written), 64'(vecs[v].exp_written));
      chk($sformatf("vec%0d tbl entry%0d", v, vecs[v].chk_idx),
          64'(bank[vecs[v].chk_idx*WW +: WW]), 64'(vecs[v].exp_entry));
    end

    // Reset arriving while a write sits in stage 1 must drop it
    step(1'b1, 11'd124, 36'h77, 1'b0, "inflight req");
    do_reset("inflight");
    step(1'b0, 11'd0, 36'h0, 1'b0, "inflight post1");
    step(1'b0, 11'd0, 36'h0, 1'b0, "inflight post2");
    chk("inflight entry1", 64'(bank[1*WW +: WW]), 64'h0);
    chk("inflight written", 64'(written), 64'h0);

`ifdef TRANSLATED_BANK_READBACK_EN
    step(1'b1, 11'd125, 36'h5, 1'b0, "rb w5");
    step(1'b0, 11'd0, 36'h0, 1'b0, "rb idle");
    step(1'b1, 11'd125, 36'h6, 1'b0, "rb w6");
    rd_addr = 11'd125;
    step(1'b0, 11'd0, 36'h0, 1'b0, "rb same-edge");
    chk("rb read-before-write", 64'(rd_data), 64'h5);
    step(1'b0, 11'd0, 36'h0, 1'b0, "rb next");
    chk("rb read-after", 64'(rd_data), 64'h6);
    rd_addr = 11'd200;
    step(1'b0, 11'd0, 36'h0, 1'b0, "rb out-of-range");
    chk("rb oor zero", 64'(rd_data), 64'h0);
`endif

    for (int c = 0; c < 400; c++) begin
      r = {$urandom(), $urandom()};
      ra = 11'($urandom_range(BASE + EC + 4, BASE - 5));
`ifdef TRANSLATED_BANK_READBACK_EN
      rd_addr = 11'($urandom_range(BASE + EC + 2, BASE - 3));
`endif
      step(1'($urandom_range(1, 0) | $urandom_range(1, 0)), ra, r[WW-1:0],
           1'($urandom_range(7, 0) == 0), $sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
